alu_seq: RTL

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Executes the existing logic and arithmetic ops in one registered cycle.
- Adds iterative signed/unsigned multiply and divide into internal HI/LO registers, read back with MFHI/MFLO.
- Sits in the EX stage; the controller issues work with a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq_muldiv_iter.sv | 97 +++++++++
 rtl/alu_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the sequential ALU and its bench.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bundle between the EX-stage controller (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 4
);
    logic             start;
    logic [CTRLW-1:0] ctrl;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ou;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ovf;

    modport master (
        output start, ctrl, in1, in2,
        input  busy, done, ou, zero, hi, lo, ovf
    );

    modport slave (
        input  start, ctrl, in1, in2,
        output busy, done, ou, zero, hi, lo, ovf
    );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative multiply/divide engine: WIDTH shift-add or restoring-divide steps on
// operand magnitudes, with the sign fix-up applied to the final step's result.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             fin_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             run_q, div_q, neg_q, rneg_q, divz_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] a_q, a_d, b_q;
    logic [WIDTH:0]   step_sum, step_sh, step_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // r_q is the running high half (multiply) or partial remainder (divide);
    // a_q is the multiplier shifting out or the dividend shifting into the quotient.
    always_comb begin
        r_d       = r_q;
        a_d       = a_q;
        step_sum  = a_q[0] ? (r_q + {1'b0, b_q}) : r_q;
        step_sh   = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
        step_diff = step_sh - {1'b0, b_q};
        if (div_q) begin
            if (!step_diff[WIDTH]) begin
                r_d = step_diff;
                a_d = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                r_d = step_sh;
                a_d = {a_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            r_d = {1'b0, step_sum[WIDTH:1]};
            a_d = {step_sum[0], a_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {r_d[WIDTH-1:0], a_d};
        prod_fix = neg_q ? -prod : prod;
        // Divide by zero naturally leaves remainder = |in1|; only the quotient needs forcing.
        quo_fix  = divz_q ? '1 : (neg_q ? -a_d : a_d);
        rem_fix  = rneg_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
        hi_o     = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_o     = div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    assign fin_o = run_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            divz_q <= 1'b0;
            cnt_q  <= '0;
            r_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (go_i) begin
            run_q  <= 1'b1;
            div_q  <= is_div_i;
            neg_q  <= is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q <= is_signed_i && a_i[WIDTH-1];
            divz_q <= (b_i == '0);
            cnt_q  <= '0;
            r_q    <= '0;
            a_q    <= mag(a_i, is_signed_i && a_i[WIDTH-1]);
            b_q    <= mag(b_i, is_signed_i && b_i[WIDTH-1]);
        end else if (run_q) begin
            r_q   <= r_d;
            a_q   <= a_d;
            cnt_q <= cnt_q + 1'b1;
            if (fin_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative MUL/DIV into HI/LO.
// Define ALU_OVF_EN to build the registered signed ADD/SUB overflow flag.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTRLW = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    state_t           state_q;
    logic [WIDTH-1:0] ou_q, hi_q, lo_q;
    logic             zero_q, busy_q, done_q;
    logic [CTRLW-1:0] op;
    logic [WIDTH-1:0] alu_d, sum_d, diff_d;
    logic             is_md, is_div, is_signed, md_go, md_fin;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign op        = bus.ctrl;
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_md     = is_div || (op == OP_MULT) || (op == OP_MULTU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign md_go     = (state_q == S_IDLE) && bus.start && is_md;
    assign sum_d     = bus.in1 + bus.in2;
    assign diff_d    = bus.in1 - bus.in2;

    always_comb begin
        alu_d = '0;
        case (op)
            OP_AND:  alu_d = bus.in1 & bus.in2;
            OP_OR:   alu_d = bus.in1 | bus.in2;
            OP_ADD:  alu_d = sum_d;
            OP_SUB:  alu_d = diff_d;
            OP_NOR:  alu_d = ~(bus.in1 | bus.in2);
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
            OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
            OP_MFHI: alu_d = hi_q;
            OP_MFLO: alu_d = lo_q;
            default: alu_d = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = 1'b0;
        if (op == OP_ADD) begin
            ovf_d = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (sum_d[WIDTH-1] != bus.in1[WIDTH-1]);
        end else if (op == OP_SUB) begin
            ovf_d = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (diff_d[WIDTH-1] != bus.in1[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .go_i        (md_go),
        .is_div_i    (is_div),
        .is_signed_i (is_signed),
        .a_i         (bus.in1),
        .b_i         (bus.in2),
        .fin_o       (md_fin),
        .hi_o        (md_hi),
        .lo_o        (md_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ou_q    <= '0;
            zero_q  <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (is_md) begin
                            state_q <= is_div ? S_DIV : S_MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_FIN;
                            ou_q    <= alu_d;
                            zero_q  <= (alu_d == '0);
                            done_q  <= 1'b1;
`ifdef ALU_OVF_EN
                            ovf_q   <= ovf_d;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (md_fin) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= md_hi;
                        lo_q    <= md_lo;
                        ou_q    <= md_lo;
                        zero_q  <= (md_lo == '0);
`ifdef ALU_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ou   = ou_q;
    assign bus.zero = zero_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
